alu_redirect_arbiter: RTL and testbench
=======================================

# alu_redirect_arbiter

Collects branch-resolution results from all ALU branch units each cycle and selects the oldest mispredicted branch. It registers that branch as a single pending redirect request toward the frontend/FSQ, and holds it until the frontend accepts it. Younger or squashed requests are suppressed. The block sits directly downstream of the ALU execute stage and produces the backend branch-redirect path.

## Interface
- `ALU_NUM`, default 4: number of ALU branch result ports.
- `ROB_IDX_W`, default 6: ROB index width. Each robIdx carries one extra MSB wrap flag.
- `FSQ_IDX_W`, default 5: FSQ index width.
- `PRED_W`, default 3: width of the fetch-stream offset.
- `VADDR_W`, default 32: target address width.

Ports:
- `clk` in 1: clock. One clock domain.
- `rst` in 1: asynchronous, active-high reset.
- `br_valid` in `ALU_NUM`: per-ALU branch result valid.
- `br_rob_idx` in `ALU_NUM` x (`ROB_IDX_W`+1): `{wrap, idx}` per port.
- `br_fsq_idx` in `ALU_NUM` x `FSQ_IDX_W`: fetch stream of the branch.
- `br_offset` in `ALU_NUM` x `PRED_W`: slot within the stream.
- `br_target` in `ALU_NUM` x `VADDR_W`: resolved next PC.
- `br_direction` in `ALU_NUM`: resolved taken.
- `br_error` in `ALU_NUM`: misprediction detected.
- `flush_valid` in 1: backend flush, from an exception or commit redirect.
- `flush_rob_idx` in `ROB_IDX_W`+1: flush point. Entries at or younger than this are squashed.
- `redirect_ready` in 1: frontend accepts the redirect.
- `redirect_valid` out 1: pending redirect present.
- `redirect_rob_idx` out `ROB_IDX_W`+1: robIdx of the redirect.
- `redirect_fsq_idx` out `FSQ_IDX_W`: FSQ index of the redirect.
- `redirect_offset` out `PRED_W`: slot offset of the redirect.
- `redirect_target` out `VADDR_W`: redirect target PC.
- `redirect_direction` out 1: resolved direction of the redirect.
- `branch_cnt` out 32: total valid branch results, wrapping.
- `mispred_cnt` out 32: total valid results with `br_error` set, wrapping.

## Operation
- **Age rule.** A is older than B when either:
  - A.wrap == B.wrap and A.idx < B.idx, or
  - A.wrap != B.wrap and A.idx > B.idx.
- Equal `{wrap, idx}` counts as "not older".
- **Candidates.** Port i is a candidate when `br_valid[i] & br_error[i]` holds and it is not squashed.
  - Squashed means `flush_valid` is high and the port is not older than `flush_rob_idx`.
- **Selection.** The oldest candidate is chosen through a log2(`ALU_NUM`) comparison tree. On equal age, the lower port index wins.
- **States.** IDLE (`redirect_valid`=0) and PENDING (`redirect_valid`=1).
- **Transitions.** Priority order, evaluated each cycle:
  1. Pending flushed. PENDING with `flush_valid`, and pending not older than `flush_rob_idx` → pending is dropped. A surviving candidate can still load, since it is older than the flush point.
  2. Load. A candidate exists, and either the pending slot is empty after step 1, or `redirect_valid & redirect_ready` holds this cycle, or the candidate is older than pending → load the candidate into PENDING.
  3. Accept. `redirect_valid & redirect_ready` with no load → go to IDLE.
  4. Otherwise → hold.
- **Payload replacement.** The pending payload may change while `redirect_valid` stays high, when an older candidate replaces it. The consumer samples only on `valid & ready`.
- **Younger candidates are dropped.** A candidate younger than a held pending entry is discarded, because it will be squashed by that redirect.
- **Counters.**
  - `branch_cnt` += popcount(`br_valid`).
  - `mispred_cnt` += popcount(`br_valid & br_error`).
  - Both count irrespective of flush and wrap at 2^32.

## Timing
- **Latency.** A `br_error` sampled at edge T gives `redirect_valid`=1 with its payload after edge T, i.e. visible in cycle T+1. One cycle, fully registered.
- **Inputs.** No combinational path from inputs to any output.
- **`redirect_ready`.** Acts at the edge where it is sampled together with `redirect_valid`. `redirect_ready` while IDLE has no effect.
- **Reset.** Asynchronous, active-high. While `rst`=1, all outputs read 0: valid, payload, and both counters. The state is IDLE. A pending redirect is discarded when reset asserts mid-operation.
- **Back-to-back.** Accept and a new load in the same cycle keep `redirect_valid`=1 with the new payload on the next cycle. No bubble.
- **Flush and candidates.** Flush and candidate in the same cycle are evaluated against the same flush point.

## Test plan
- **Single mispredict.** Port 1 presents valid, error, rob `{0,5}`, target `0x8000_0040`. With `ready`=0, the next cycle shows `redirect_valid`=1, rob `{0,5}`, target `0x8000_0040`. It holds until `ready`=1, then returns to IDLE a cycle later. `mispred_cnt`=1.
- **Multi-port and wrap selection.** Ports 0..3 present errors at robs `{1,2}`, `{0,60}`, `{0,61}`, `{1,0}` → `redirect_rob_idx`=`{0,60}`. Equal-age ports 0 and 2 → port 0 wins.
- **Replacement while pending.** Pending `{0,20}`, `ready`=0. Input `{0,10}` replaces it next cycle. Input `{0,30}` is ignored. `mispred_cnt` counts all of them.
- **Flush.** Pending `{0,20}` with flush `{0,15}` → IDLE next cycle. Same cycle, candidate `{0,12}` → pending `{0,12}`. Flush `{0,25}` leaves `{0,20}` pending.
- **Accept plus load.** Pending `{0,8}`, `ready`=1, candidate `{0,9}` → next cycle `redirect_valid`=1, rob `{0,9}`.
- **Asynchronous reset mid-PENDING.** All outputs are 0 immediately, without waiting for a clock edge. After release, `br_valid`=0 → remains IDLE.

Source files
------------

// File: rtl/alu_redirect_arbiter.sv
// alu_redirect_arbiter: collects per-ALU branch results, picks the oldest
// surviving mispredict and holds it as one pending redirect toward the frontend.
//
// Handshake: redirect_valid/redirect_ready follow strict valid/ready rules.
// A transfer happens at a clock edge where both are high. The payload may be
// replaced by an older mispredict while valid stays high. The consumer must
// only sample it on valid & ready.
module alu_redirect_arbiter #(
  parameter int ALU_NUM   = 4,
  parameter int ROB_IDX_W = 6,
  parameter int FSQ_IDX_W = 5,
  parameter int PRED_W    = 3,
  parameter int VADDR_W   = 32
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [ALU_NUM-1:0]                  br_valid,
  input  logic [ALU_NUM-1:0][ROB_IDX_W:0]     br_rob_idx,
  input  logic [ALU_NUM-1:0][FSQ_IDX_W-1:0]   br_fsq_idx,
  input  logic [ALU_NUM-1:0][PRED_W-1:0]      br_offset,
  input  logic [ALU_NUM-1:0][VADDR_W-1:0]     br_target,
  input  logic [ALU_NUM-1:0]                  br_direction,
  input  logic [ALU_NUM-1:0]                  br_error,
  input  logic                                flush_valid,
  input  logic [ROB_IDX_W:0]                  flush_rob_idx,
  input  logic                                redirect_ready,
  output logic                                redirect_valid,
  output logic [ROB_IDX_W:0]                  redirect_rob_idx,
  output logic [FSQ_IDX_W-1:0]                redirect_fsq_idx,
  output logic [PRED_W-1:0]                   redirect_offset,
  output logic [VADDR_W-1:0]                  redirect_target,
  output logic                                redirect_direction,
  output logic [31:0]                         branch_cnt,
  output logic [31:0]                         mispred_cnt
);

  localparam int LVLS = $clog2(ALU_NUM);
  localparam int N2   = 1 << LVLS;
  localparam int IDXW = (LVLS > 0) ? LVLS : 1;

  typedef enum logic {IDLE = 1'b0, PENDING = 1'b1} state_e;

  state_e               state_q;
  logic [ROB_IDX_W:0]   rob_q;
  logic [FSQ_IDX_W-1:0] fsq_q;
  logic [PRED_W-1:0]    off_q;
  logic [VADDR_W-1:0]   tgt_q;
  logic                 dir_q;
  logic [31:0]          branch_cnt_q, branch_cnt_d;
  logic [31:0]          mispred_cnt_q, mispred_cnt_d;

  // a is strictly older than b under the wrap-flag ROB ordering
  function automatic logic older(input logic [ROB_IDX_W:0] a, input logic [ROB_IDX_W:0] b);
    if (a[ROB_IDX_W] == b[ROB_IDX_W]) return a[ROB_IDX_W-1:0] < b[ROB_IDX_W-1:0];
    else                              return a[ROB_IDX_W-1:0] > b[ROB_IDX_W-1:0];
  endfunction

  // Candidates: mispredicts not squashed by a same-cycle flush
  logic [ALU_NUM-1:0] cand;
  always_comb begin
    for (int i = 0; i < ALU_NUM; i++) begin
      cand[i] = br_valid[i] & br_error[i] &
                ~(flush_valid & ~older(br_rob_idx[i], flush_rob_idx));
    end
  end

  // Oldest-candidate comparison tree; left (lower port) wins on equal age
  for (genvar l = 0; l <= LVLS; l++) begin : lvl_g
    localparam int NW = N2 >> l;
    logic [NW-1:0]                v;
    logic [NW-1:0][ROB_IDX_W:0]   rob;
    logic [NW-1:0][IDXW-1:0]      id;
    if (l == 0) begin : leaf_g
      for (genvar i = 0; i < NW; i++) begin : p_g
        if (i < ALU_NUM) begin : real_g
          assign v[i]   = cand[i];
          assign rob[i] = br_rob_idx[i];
          assign id[i]  = IDXW'(i);
        end else begin : pad_g
          assign v[i]   = 1'b0;
          assign rob[i] = '0;
          assign id[i]  = '0;
        end
      end
    end else begin : node_g
      for (genvar i = 0; i < NW; i++) begin : n_g
        logic pick_l;
        assign pick_l = lvl_g[l-1].v[2*i] &
                        (~lvl_g[l-1].v[2*i+1] |
                         ~older(lvl_g[l-1].rob[2*i+1], lvl_g[l-1].rob[2*i]));
        assign v[i]   = lvl_g[l-1].v[2*i] | lvl_g[l-1].v[2*i+1];
        assign rob[i] = pick_l ? lvl_g[l-1].rob[2*i] : lvl_g[l-1].rob[2*i+1];
        assign id[i]  = pick_l ? lvl_g[l-1].id[2*i]  : lvl_g[l-1].id[2*i+1];
      end
    end
  end

  logic               sel_valid;
  logic [ROB_IDX_W:0] sel_rob;
  logic [IDXW-1:0]    sel_id;
  assign sel_valid = lvl_g[LVLS].v[0];
  assign sel_rob   = lvl_g[LVLS].rob[0];
  assign sel_id    = lvl_g[LVLS].id[0];

  // Pending survival, handshake and load decision
  logic pend_live, accept, load;
  always_comb begin
    pend_live = (state_q == PENDING) &
                ~(flush_valid & ~older(rob_q, flush_rob_idx));
    accept    = (state_q == PENDING) & redirect_ready;
    load      = sel_valid & (~pend_live | accept | older(sel_rob, rob_q));
  end

  // Event counters, flush-independent
  always_comb begin
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    for (int i = 0; i < ALU_NUM; i++) begin
      branch_cnt_d  = branch_cnt_d  + 32'(br_valid[i]);
      mispred_cnt_d = mispred_cnt_d + 32'(br_valid[i] & br_error[i]);
    end
  end

  // Redirect FSM with registered payload and counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      rob_q         <= '0;
      fsq_q         <= '0;
      off_q         <= '0;
      tgt_q         <= '0;
      dir_q         <= 1'b0;
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
      if (load) begin
        state_q <= PENDING;
        rob_q   <= sel_rob;
        fsq_q   <= br_fsq_idx[sel_id];
        off_q   <= br_offset[sel_id];
        tgt_q   <= br_target[sel_id];
        dir_q   <= br_direction[sel_id];
      end else if (~pend_live | accept) begin
        state_q <= IDLE;
        rob_q   <= '0;
        fsq_q   <= '0;
        off_q   <= '0;
        tgt_q   <= '0;
        dir_q   <= 1'b0;
      end
    end
  end

  assign redirect_valid     = (state_q == PENDING);
  assign redirect_rob_idx   = rob_q;
  assign redirect_fsq_idx   = fsq_q;
  assign redirect_offset    = off_q;
  assign redirect_target    = tgt_q;
  assign redirect_direction = dir_q;
  assign branch_cnt         = branch_cnt_q;
  assign mispred_cnt        = mispred_cnt_q;

endmodule

// File: tb/tb_alu_redirect_arbiter.sv
// Directed bench for alu_redirect_arbiter: hand-computed vectors, immediate
// assertions at each comparison point, one summary line at the end.
module tb_alu_redirect_arbiter;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [3:0]           br_valid;
  logic [3:0][6:0]      br_rob_idx;
  logic [3:0][4:0]      br_fsq_idx;
  logic [3:0][2:0]      br_offset;
  logic [3:0][31:0]     br_target;
  logic [3:0]           br_direction;
  logic [3:0]           br_error;
  logic                 flush_valid;
  logic [6:0]           flush_rob_idx;
  logic                 redirect_ready;
  logic                 redirect_valid;
  logic [6:0]           redirect_rob_idx;
  logic [4:0]           redirect_fsq_idx;
  logic [2:0]           redirect_offset;
  logic [31:0]          redirect_target;
  logic                 redirect_direction;
  logic [31:0]          branch_cnt;
  logic [31:0]          mispred_cnt;

  int errors = 0;
  int checks = 0;

  alu_redirect_arbiter dut (
    .clk                (clk),
    .rst                (rst),
    .br_valid           (br_valid),
    .br_rob_idx         (br_rob_idx),
    .br_fsq_idx         (br_fsq_idx),
    .br_offset          (br_offset),
    .br_target          (br_target),
    .br_direction       (br_direction),
    .br_error           (br_error),
    .flush_valid        (flush_valid),
    .flush_rob_idx      (flush_rob_idx),
    .redirect_ready     (redirect_ready),
    .redirect_valid     (redirect_valid),
    .redirect_rob_idx   (redirect_rob_idx),
    .redirect_fsq_idx   (redirect_fsq_idx),
    .redirect_offset    (redirect_offset),
    .redirect_target    (redirect_target),
    .redirect_direction (redirect_direction),
    .branch_cnt         (branch_cnt),
    .mispred_cnt        (mispred_cnt)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic clear_br();
    br_valid     = '0;
    br_rob_idx   = '0;
    br_fsq_idx   = '0;
    br_offset    = '0;
    br_target    = '0;
    br_direction = '0;
    br_error     = '0;
  endtask

  // Port p gets fsq = p+3, offset = p, direction = p[0]
  task automatic drive(input int p, input logic [6:0] rob, input logic [31:0] tgt, input logic err);
    br_valid[p]     = 1'b1;
    br_error[p]     = err;
    br_rob_idx[p]   = rob;
    br_fsq_idx[p]   = 5'(p + 3);
    br_offset[p]    = 3'(p);
    br_target[p]    = tgt;
    br_direction[p] = p[0];
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    flush_valid = 1'b0;
    flush_rob_idx = '0;
    redirect_ready = 1'b0;
    clear_br();
    #2;
    chk("rst_valid", 64'(redirect_valid), 64'd0);
    chk("rst_rob", 64'(redirect_rob_idx), 64'd0);
    chk("rst_target", 64'(redirect_target), 64'd0);
    chk("rst_bcnt", 64'(branch_cnt), 64'd0);
    chk("rst_mcnt", 64'(mispred_cnt), 64'd0);
    step();
    rst = 1'b0;
    step();
    chk("idle_valid", 64'(redirect_valid), 64'd0);

    // Single mispredict on port 1
    drive(1, 7'h05, 32'h8000_0040, 1'b1);
    step(); clear_br();
    chk("single_valid", 64'(redirect_valid), 64'd1);
    chk("single_rob", 64'(redirect_rob_idx), 64'h05);
    chk("single_target", 64'(redirect_target), 64'h8000_0040);
    chk("single_fsq", 64'(redirect_fsq_idx), 64'd4);
    chk("single_off", 64'(redirect_offset), 64'd1);
    chk("single_dir", 64'(redirect_direction), 64'd1);
    chk("single_mcnt", 64'(mispred_cnt), 64'd1);
    step();
    chk("single_hold", 64'(redirect_valid), 64'd1);
    chk("single_hold_rob", 64'(redirect_rob_idx), 64'h05);
    redirect_ready = 1'b1;
    step();
    redirect_ready = 1'b0;
    chk("single_accept", 64'(redirect_valid), 64'd0);
    chk("single_bcnt", 64'(branch_cnt), 64'd1);

    // Wrap-aware selection: {0,60} is oldest
    drive(0, 7'h42, 32'h1000, 1'b1);
    drive(1, 7'h3C, 32'h1004, 1'b1);
    drive(2, 7'h3D, 32'h1008, 1'b1);
    drive(3, 7'h40, 32'h100C, 1'b1);
    step(); clear_br();
    chk("wrap_rob", 64'(redirect_rob_idx), 64'h3C);
    chk("wrap_target", 64'(redirect_target), 64'h1004);
    chk("wrap_mcnt", 64'(mispred_cnt), 64'd5);

    // Accept plus equal-age tie: port 0 beats port 2, non-error port 1 ignored
    redirect_ready = 1'b1;
    drive(0, 7'h07, 32'h00A0, 1'b1);
    drive(1, 7'h01, 32'h00A1, 1'b0);
    drive(2, 7'h07, 32'h00A2, 1'b1);
    step(); clear_br();
    chk("tie_valid", 64'(redirect_valid), 64'd1);
    chk("tie_target", 64'(redirect_target), 64'h00A0);
    chk("tie_bcnt", 64'(branch_cnt), 64'd8);
    chk("tie_mcnt", 64'(mispred_cnt), 64'd7);
    step();
    redirect_ready = 1'b0;
    chk("tie_drain", 64'(redirect_valid), 64'd0);

    // Replacement while pending
    drive(0, 7'h14, 32'h2000, 1'b1);
    step(); clear_br();
    chk("repl_first", 64'(redirect_rob_idx), 64'h14);
    drive(3, 7'h0A, 32'h200C, 1'b1);
    step(); clear_br();
    chk("repl_older_rob", 64'(redirect_rob_idx), 64'h0A);
    chk("repl_older_tgt", 64'(redirect_target), 64'h200C);
    drive(2, 7'h1E, 32'h2008, 1'b1);
    step(); clear_br();
    chk("repl_younger_valid", 64'(redirect_valid), 64'd1);
    chk("repl_younger_rob", 64'(redirect_rob_idx), 64'h0A);
    chk("repl_mcnt", 64'(mispred_cnt), 64'd10);
    redirect_ready = 1'b1;
    step();
    redirect_ready = 1'b0;
    chk("repl_drain", 64'(redirect_valid), 64'd0);

    // Flush drops pending, older same-cycle candidate still loads
    drive(0, 7'h14, 32'h3000, 1'b1);
    step(); clear_br();
    chk("flush_pend", 64'(redirect_rob_idx), 64'h14);
    flush_valid = 1'b1; flush_rob_idx = 7'h0F;
    drive(1, 7'h0C, 32'h3004, 1'b1);
    step(); clear_br(); flush_valid = 1'b0;
    chk("flush_load_valid", 64'(redirect_valid), 64'd1);
    chk("flush_load_rob", 64'(redirect_rob_idx), 64'h0C);
    chk("flush_load_tgt", 64'(redirect_target), 64'h3004);
    flush_valid = 1'b1; flush_rob_idx = 7'h0B;
    step(); flush_valid = 1'b0;
    chk("flush_idle", 64'(redirect_valid), 64'd0);
    // Candidate younger than flush point is squashed, still counted
    flush_valid = 1'b1; flush_rob_idx = 7'h0F;
    drive(1, 7'h10, 32'h3008, 1'b1);
    step(); clear_br(); flush_valid = 1'b0;
    chk("flush_squash", 64'(redirect_valid), 64'd0);
    chk("flush_mcnt", 64'(mispred_cnt), 64'd13);
    drive(0, 7'h14, 32'h300C, 1'b1);
    step(); clear_br();
    flush_valid = 1'b1; flush_rob_idx = 7'h19;
    step(); flush_valid = 1'b0;
    chk("flush_survive_valid", 64'(redirect_valid), 64'd1);
    chk("flush_survive_rob", 64'(redirect_rob_idx), 64'h14);
    redirect_ready = 1'b1;
    step();
    redirect_ready = 1'b0;
    chk("flush_drain", 64'(redirect_valid), 64'd0);

    // Accept plus younger load, no bubble
    drive(0, 7'h08, 32'h4000, 1'b1);
    step(); clear_br();
    chk("b2b_first", 64'(redirect_rob_idx), 64'h08);
    redirect_ready = 1'b1;
    drive(2, 7'h09, 32'h4008, 1'b1);
    step(); clear_br(); redirect_ready = 1'b0;
    chk("b2b_valid", 64'(redirect_valid), 64'd1);
    chk("b2b_rob", 64'(redirect_rob_idx), 64'h09);
    chk("b2b_tgt", 64'(redirect_target), 64'h4008);
    chk("b2b_bcnt", 64'(branch_cnt), 64'd17);
    chk("b2b_mcnt", 64'(mispred_cnt), 64'd16);

    // Asynchronous reset mid-pending, away from any clock edge
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", 64'(redirect_valid), 64'd0);
    chk("arst_rob", 64'(redirect_rob_idx), 64'd0);
    chk("arst_target", 64'(redirect_target), 64'd0);
    chk("arst_bcnt", 64'(branch_cnt), 64'd0);
    chk("arst_mcnt", 64'(mispred_cnt), 64'd0);
    step();
    rst = 1'b0;
    step();
    step();
    chk("post_rst_valid", 64'(redirect_valid), 64'd0);
    chk("post_rst_bcnt", 64'(branch_cnt), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
